// File: rtl/fir_filter_tdm.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_tdm
// Brief    : Time-multiplexed FIR, one shared MAC, shadow/active coefficient
//            banks, arithmetic-shift scaling. Build macro FIR_SAT_EN selects
//            output saturation instead of two's-complement wrap.
// Revision : 1.0
// ============================================================================
module fir_filter_tdm #(
    parameter int NTAPS = 21,
    parameter int DW    = 18,
    parameter int CW    = 25,
    parameter int OW    = 18,
    parameter int SHIFT = 23,
    parameter int ACCW  = 48
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [DW-1:0] in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [OW-1:0] out,
    output logic                 out_valid,
    input  logic signed [CW-1:0] cfg_din,
    input  logic                 cfg_we,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic [31:0]          len
);
    localparam int                   c_TW    = $clog2(NTAPS);
    localparam int                   c_PW    = DW + CW;
    localparam logic [c_TW-1:0]      c_LAST  = c_TW'(NTAPS - 1);
    localparam logic [c_TW-1:0]      c_ONE   = c_TW'(1);
    localparam logic signed [CW-1:0] c_UNITY = CW'(1) << SHIFT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic signed [DW-1:0]   r_hist   [NTAPS];
    logic signed [CW-1:0]   r_shadow [NTAPS];
    logic signed [CW-1:0]   r_coef   [NTAPS];
    logic [c_TW-1:0]        r_wp;
    logic [c_TW-1:0]        r_rd;
    logic [c_TW-1:0]        r_tap;
    logic signed [c_PW-1:0] r_prod;
    logic                   r_pv;
    logic                   r_pfirst;
    logic signed [ACCW-1:0] r_acc;
    logic                   r_pend;
    logic                   r_in_ready;
    logic signed [OW-1:0]   r_out;
    logic                   r_out_valid;

    logic signed [DW-1:0]   w_x;
    logic signed [CW-1:0]   w_c;
    logic signed [c_PW-1:0] w_mul;
    logic signed [ACCW-1:0] w_pext;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_tot;
    logic signed [ACCW-1:0] w_y;
    logic signed [OW-1:0]   w_out;

    assign w_x    = r_hist[r_rd];
    assign w_c    = r_coef[r_tap];
    assign w_mul  = $signed({{CW{w_x[DW-1]}}, w_x}) * $signed({{DW{w_c[CW-1]}}, w_c});
    assign w_pext = {{(ACCW-c_PW){r_prod[c_PW-1]}}, r_prod};
    assign w_sum  = r_acc + w_pext;
    // The first registered product of a pass replaces the stale accumulator.
    assign w_tot  = r_pfirst ? w_pext : w_sum;
    assign w_y    = w_tot >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACCW-1:0] c_OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        w_out = w_y[OW-1:0];
        if (w_y > c_OMAX)
            w_out = c_OMAX[OW-1:0];
        else if (w_y < c_OMIN)
            w_out = c_OMIN[OW-1:0];
    end
`else
    logic w_unused_hi;
    assign w_out       = w_y[OW-1:0];
    assign w_unused_hi = ^w_y[ACCW-1:OW];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_rd        <= '0;
            r_tap       <= '0;
            r_prod      <= '0;
            r_pv        <= 1'b0;
            r_pfirst    <= 1'b0;
            r_acc       <= '0;
            r_pend      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                r_hist[k]   <= '0;
                r_shadow[k] <= (k == 0) ? c_UNITY : '0;
                r_coef[k]   <= (k == 0) ? c_UNITY : '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_pv        <= 1'b0;
            if (r_pv)
                r_acc <= w_tot;

            if (cfg_we) begin
                for (int k = 0; k < NTAPS - 1; k++)
                    r_shadow[k] <= r_shadow[k+1];
                r_shadow[NTAPS-1] <= cfg_din;
            end

            // Bank swap only while idle, so a pass never mixes coefficient sets.
            if ((r_state == S_IDLE) && r_pend) begin
                for (int k = 0; k < NTAPS; k++)
                    r_coef[k] <= r_shadow[k];
                r_pend <= 1'b0;
            end else if (cfg_commit) begin
                r_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_hist[r_wp] <= in;
                        r_rd         <= r_wp;
                        r_wp         <= (r_wp == c_LAST) ? '0 : r_wp + c_ONE;
                        r_tap        <= '0;
                        r_in_ready   <= 1'b0;
                        r_state      <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_prod   <= w_mul;
                    r_pv     <= 1'b1;
                    r_pfirst <= (r_tap == '0);
                    r_rd     <= (r_rd == '0) ? c_LAST : r_rd - c_ONE;
                    r_tap    <= r_tap + c_ONE;
                    if (r_tap == c_LAST)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_out       <= w_out;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign cfg_busy  = r_pend;
    assign len       = 32'(NTAPS);

endmodule
`default_nettype wire
